pic_priority_arbiter: RTL and testbench

Parametrised priority arbiter with in-service tracking for the PIC datapath. Sits between the interrupt request register (IRR) / mask register (IMR) and the CPU acknowledge sequencer. It resolves the highest-priority unmasked request against the in-service register (ISR) under fully-nested, rotating or specific-rotation priority. It raises the CPU interrupt, grants on acknowledge, and executes EOI/rotation commands.

---
 rtl/pic_priority_arbiter.sv | 156 +++++++++++++++
 tb/tb_pic_priority_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_priority_arbiter.sv
// PIC priority arbiter: resolves the highest-priority unmasked request
// against the in-service register, raises int_req and grants on int_ack.
module pic_priority_arbiter #(
   parameter int N     = 8,
   parameter int IDX_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     irq_req,
   input  logic [N-1:0]     irq_mask,
   input  logic             auto_eoi,
   output logic             int_req,
   input  logic             int_ack,
   output logic             ack_valid,
   output logic [IDX_W-1:0] ack_index,
   output logic [N-1:0]     clr_irr,
   output logic [N-1:0]     isr,
   output logic [IDX_W-1:0] lowest_prio,
   input  logic             cmd_valid,
   input  logic [2:0]       cmd_op,
   input  logic [IDX_W-1:0] cmd_level
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_GRANT
   } state_t;

   state_t state, state_nxt;

   logic             auto_rot;
   logic [N-1:0]     pend;
   logic [IDX_W:0]   rk;
   logic             cand_found, isr_found, qualify, grant;
   logic [IDX_W-1:0] cand_idx, isr_idx;
   logic [IDX_W:0]   cand_rank, isr_rank;
   logic [N-1:0]     cand_oh, grant_set, eoi_clr;
   logic             level_ok, cmd_lp_we, rot_we, rot_val;
   logic [IDX_W-1:0] cmd_lp;

   // Rank 0 is the channel just after the lowest-priority pointer.
   function automatic logic [IDX_W:0] rank_of(
      input logic [IDX_W-1:0] ch,
      input logic [IDX_W-1:0] lp
   );
      logic [IDX_W+1:0] s;
      s = (IDX_W+2)'(ch) + (IDX_W+2)'(N) - (IDX_W+2)'(lp) - (IDX_W+2)'(1);
      if (s >= (IDX_W+2)'(N)) s = s - (IDX_W+2)'(N);
      return s[IDX_W:0];
   endfunction

   assign pend = irq_req & ~irq_mask;

   always_comb begin
      rk         = '0;
      cand_found = 1'b0;
      cand_idx   = '0;
      cand_rank  = '0;
      isr_found  = 1'b0;
      isr_idx    = '0;
      isr_rank   = '0;
      for (int i = 0; i < N; i++) begin
         rk = rank_of(IDX_W'(i), lowest_prio);
         if (pend[i] && (!cand_found || rk < cand_rank)) begin
            cand_found = 1'b1;
            cand_idx   = IDX_W'(i);
            cand_rank  = rk;
         end
         if (isr[i] && (!isr_found || rk < isr_rank)) begin
            isr_found = 1'b1;
            isr_idx   = IDX_W'(i);
            isr_rank  = rk;
         end
      end
   end

   assign qualify   = cand_found && (!isr_found || cand_rank < isr_rank);
   assign grant     = (state == S_REQ) && int_ack;
   assign cand_oh   = N'(1) << cand_idx;
   assign grant_set = (grant && qualify && !auto_eoi) ? cand_oh : '0;
   assign level_ok  = (IDX_W+1)'(cmd_level) < (IDX_W+1)'(N);

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (qualify) state_nxt = S_REQ;
         S_REQ:   if (int_ack) state_nxt = S_GRANT;
         S_GRANT: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      eoi_clr   = '0;
      cmd_lp_we = 1'b0;
      cmd_lp    = '0;
      rot_we    = 1'b0;
      rot_val   = 1'b0;
      if (cmd_valid) begin
         unique case (cmd_op)
            3'b001: if (isr_found) eoi_clr[isr_idx] = 1'b1;
            3'b011: if (isr_found) begin
               eoi_clr[isr_idx] = 1'b1;
               cmd_lp_we        = 1'b1;
               cmd_lp           = isr_idx;
            end
            3'b010: if (level_ok) eoi_clr[cmd_level] = 1'b1;
            3'b101: if (level_ok) begin
               eoi_clr[cmd_level] = 1'b1;
               cmd_lp_we          = 1'b1;
               cmd_lp             = cmd_level;
            end
            3'b100: if (level_ok) begin
               cmd_lp_we = 1'b1;
               cmd_lp    = cmd_level;
            end
            3'b110: begin
               rot_we  = 1'b1;
               rot_val = 1'b1;
            end
            3'b111: rot_we = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         int_req     <= 1'b0;
         ack_valid   <= 1'b0;
         ack_index   <= '0;
         clr_irr     <= '0;
         isr         <= '0;
         lowest_prio <= LAST;
         auto_rot    <= 1'b0;
      end else begin
         state     <= state_nxt;
         int_req   <= (state_nxt == S_REQ);
         ack_valid <= grant;
         clr_irr   <= (grant && qualify) ? cand_oh : '0;
         if (grant) ack_index <= qualify ? cand_idx : LAST;
         isr <= (isr & ~eoi_clr) | grant_set;
         // A command pointer write overrides an auto-rotate grant.
         if (cmd_lp_we)
            lowest_prio <= cmd_lp;
         else if (grant && qualify && auto_eoi && auto_rot)
            lowest_prio <= cand_idx;
         if (rot_we) auto_rot <= rot_val;
      end
   end

endmodule

// File: tb/tb_pic_priority_arbiter.sv
// Bench for pic_priority_arbiter: directed plan steps followed by
// randomized traffic checked against a rank-based reference model.
module tb_pic_priority_arbiter;

   localparam int N     = 8;
   localparam int IDX_W = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [N-1:0]     irq_req;
   logic [N-1:0]     irq_mask;
   logic             auto_eoi;
   logic             int_req;
   logic             int_ack;
   logic             ack_valid;
   logic [IDX_W-1:0] ack_index;
   logic [N-1:0]     clr_irr;
   logic [N-1:0]     isr;
   logic [IDX_W-1:0] lowest_prio;
   logic             cmd_valid;
   logic [2:0]       cmd_op;
   logic [IDX_W-1:0] cmd_level;

   pic_priority_arbiter #(.N(N), .IDX_W(IDX_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .irq_req     (irq_req),
      .irq_mask    (irq_mask),
      .auto_eoi    (auto_eoi),
      .int_req     (int_req),
      .int_ack     (int_ack),
      .ack_valid   (ack_valid),
      .ack_index   (ack_index),
      .clr_irr     (clr_irr),
      .isr         (isr),
      .lowest_prio (lowest_prio),
      .cmd_valid   (cmd_valid),
      .cmd_op      (cmd_op),
      .cmd_level   (cmd_level)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [N-1:0] m_isr;
   int           m_lp;
   bit           m_rot;

   function automatic int rank(int ch, int lp);
      return (ch - lp - 1 + 2 * N) % N;
   endfunction

   function automatic int best(logic [N-1:0] v, int lp);
      int b = -1;
      for (int i = 0; i < N; i++)
         if (v[i] && (b < 0 || rank(i, lp) < rank(b, lp))) b = i;
      return b;
   endfunction

   function automatic bit qual(logic [N-1:0] p, logic [N-1:0] s, int lp);
      int c = best(p, lp);
      int h = best(s, lp);
      if (c < 0) return 1'b0;
      return (h < 0) || (rank(c, lp) < rank(h, lp));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_isr = '0;
      m_lp  = N - 1;
      m_rot = 1'b0;
   endtask

   task automatic model_step(input bit ack, input bit cv,
                             input logic [2:0] op, input int lvl,
                             output int e_idx, output logic [N-1:0] e_clr);
      logic [N-1:0] pre  = m_isr;
      int           plp  = m_lp;
      logic [N-1:0] p    = irq_req & ~irq_mask;
      logic [N-1:0] gs   = '0;
      logic [N-1:0] ec   = '0;
      int           nlp  = m_lp;
      int           c;
      int           h;
      e_idx = 0;
      e_clr = '0;
      if (ack) begin
         c = best(p, plp);
         if (qual(p, pre, plp)) begin
            e_idx    = c;
            e_clr[c] = 1'b1;
            if (!auto_eoi) gs[c] = 1'b1;
            else if (m_rot) nlp = c;
         end else begin
            e_idx = N - 1;
         end
      end
      if (cv) begin
         h = best(pre, plp);
         case (op)
            3'd1: if (h >= 0) ec[h] = 1'b1;
            3'd3: if (h >= 0) begin ec[h] = 1'b1; nlp = h; end
            3'd2: ec[lvl] = 1'b1;
            3'd5: begin ec[lvl] = 1'b1; nlp = lvl; end
            3'd4: nlp = lvl;
            3'd6: m_rot = 1'b1;
            3'd7: m_rot = 1'b0;
            default: ;
         endcase
      end
      m_isr = (pre & ~ec) | gs;
      m_lp  = nlp;
   endtask

   task automatic cmd(input logic [2:0] op, input int lvl, input string tag);
      int           d;
      logic [N-1:0] dc;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_level = IDX_W'(lvl);
      model_step(1'b0, 1'b1, op, lvl, d, dc);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      chk({tag, "_isr"}, 32'(isr), 32'(m_isr));
      chk({tag, "_lp"}, 32'(lowest_prio), m_lp);
   endtask

   task automatic ack(input bit cv, input logic [2:0] op, input int lvl,
                      input string tag);
      int           ei;
      logic [N-1:0] ec;
      int_ack   = 1'b1;
      cmd_valid = cv;
      cmd_op    = op;
      cmd_level = IDX_W'(lvl);
      model_step(1'b1, cv, op, lvl, ei, ec);
      @(negedge clk);
      int_ack   = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      chk({tag, "_av"}, 32'(ack_valid), 32'd1);
      chk({tag, "_idx"}, 32'(ack_index), ei);
      chk({tag, "_clr"}, 32'(clr_irr), 32'(ec));
      chk({tag, "_isr"}, 32'(isr), 32'(m_isr));
      chk({tag, "_lp"}, 32'(lowest_prio), m_lp);
      chk({tag, "_reqlo"}, 32'(int_req), 32'd0);
      irq_req = irq_req & ~ec;
      @(negedge clk);
      chk({tag, "_av1"}, 32'(ack_valid), 32'd0);
      chk({tag, "_clr1"}, 32'(clr_irr), 32'd0);
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (!int_req && n < 8) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_req"}, 32'(int_req), 32'd1);
   endtask

   task automatic settle(input string tag);
      repeat (3) @(negedge clk);
      chk({tag, "_req"}, 32'(int_req),
          32'(qual(irq_req & ~irq_mask, m_isr, m_lp)));
   endtask

   initial begin
      rst_n     = 1'b0;
      irq_req   = '0;
      irq_mask  = '0;
      auto_eoi  = 1'b0;
      int_ack   = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      cmd_level = '0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_req", 32'(int_req), 32'd0);
      chk("rst_av", 32'(ack_valid), 32'd0);
      chk("rst_idx", 32'(ack_index), 32'd0);
      chk("rst_clr", 32'(clr_irr), 32'd0);
      chk("rst_isr", 32'(isr), 32'd0);
      chk("rst_lp", 32'(lowest_prio), N - 1);
      rst_n = 1'b1;

      // Fully nested: IR1 beats IR3, IR3 then blocked by ISR
      irq_req = 8'h0A;
      wait_req("t1");
      ack(1'b0, 3'd0, 0, "t1");
      settle("t1_block");

      cmd(3'd1, 0, "t2_eoi");
      wait_req("t2");
      ack(1'b0, 3'd0, 0, "t2");

      // Withdrawn request gives a spurious grant
      cmd(3'd1, 0, "t3_eoi");
      irq_req = 8'h20;
      wait_req("t3");
      irq_req = 8'h00;
      @(negedge clk);
      ack(1'b0, 3'd0, 0, "t3");

      cmd(3'd4, 2, "t4_prio");
      irq_req = 8'h09;
      wait_req("t4a");
      ack(1'b0, 3'd0, 0, "t4a");
      settle("t4_block");
      cmd(3'd1, 0, "t4_eoi");
      wait_req("t4b");
      ack(1'b0, 3'd0, 0, "t4b");
      cmd(3'd1, 0, "t4_eoi2");

      // AEOI with auto-rotate
      auto_eoi = 1'b1;
      cmd(3'd6, 0, "t5_rot");
      irq_req = 8'h10;
      wait_req("t5a");
      ack(1'b0, 3'd0, 0, "t5a");
      irq_req = 8'h30;
      wait_req("t5b");
      ack(1'b0, 3'd0, 0, "t5b");
      irq_req  = 8'h00;
      auto_eoi = 1'b0;

      // Spurious grant merged with rotate-on-NS-EOI
      cmd(3'd4, 7, "t6_p7");
      irq_req = 8'h01;
      wait_req("t6a");
      ack(1'b0, 3'd0, 0, "t6a");
      irq_req = 8'h00;
      cmd(3'd4, 0, "t6_p0");
      irq_req = 8'h40;
      wait_req("t6b");
      cmd(3'd4, 7, "t6_p7b");
      irq_mask = 8'h01;
      irq_req  = 8'h41;
      ack(1'b1, 3'd3, 0, "t6b");
      irq_req  = 8'h00;
      irq_mask = 8'h00;

      for (int it = 0; it < 60; it++) begin
         logic [2:0] op;
         int         lvl;
         bit         cv;
         irq_req = '0;
         if ($urandom_range(0, 1) == 1)
            cmd(3'($urandom_range(0, 7)), int'($urandom_range(0, N - 1)),
                "rnd_cmd");
         irq_req  = N'($urandom);
         irq_mask = N'($urandom & $urandom);
         auto_eoi = 1'($urandom_range(0, 1));
         settle("rnd_idle");
         if (int_req) begin
            if ($urandom_range(0, 3) == 0) irq_req = N'($urandom);
            cv  = 1'($urandom_range(0, 1));
            lvl = int'($urandom_range(0, N - 1));
            case ($urandom_range(0, 5))
               0: op = 3'd0;
               1: op = 3'd1;
               2: op = 3'd3;
               3: op = 3'd4;
               4: op = 3'd6;
               default: op = 3'd7;
            endcase
            ack(cv, op, lvl, "rnd_ack");
         end
      end

      // Reset in the middle of an acknowledge abandons the grant
      irq_req  = '0;
      irq_mask = '0;
      auto_eoi = 1'b0;
      rst_n    = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      irq_req = 8'h04;
      wait_req("t7");
      int_ack = 1'b1;
      rst_n   = 1'b0;
      @(negedge clk);
      int_ack = 1'b0;
      chk("t7_av", 32'(ack_valid), 32'd0);
      chk("t7_req", 32'(int_req), 32'd0);
      chk("t7_clr", 32'(clr_irr), 32'd0);
      chk("t7_isr", 32'(isr), 32'(m_isr));
      chk("t7_lp", 32'(lowest_prio), m_lp);
      rst_n = 1'b1;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
